br_resolve_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle branch comparator in the RV32I pipeline.
- Evaluates all six RV32I branch conditions on WIDTH-bit operands through STAGES register stages, with a valid/ready handshake.
- Compares the resolved direction against the fetch-stage prediction and flags mispredicts.
- Keeps saturating branch and mispredict counters for performance monitoring. Sits between the EX operand muxes and the PC-redirect logic.

---
 rtl/br_resolve_pipe_pkg.sv | 24 ++
 rtl/br_resolve_pipe_cmp_core.sv | 37 +++
 rtl/br_resolve_pipe.sv | 104 ++++++++++
 tb/tb_br_resolve_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_resolve_pipe_pkg.sv
// Shared types for the branch-resolve pipeline: funct3 branch codes and the
// per-stage record that travels down the pipe.
package br_resolve_pipe_pkg;

    localparam int BR_TAG_W = 5;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_e;

    typedef struct packed {
        logic                valid;
        logic                taken;
        logic                pred;
        logic                illegal;
        logic [BR_TAG_W-1:0] tag;
    } br_stage_t;

endpackage

// File: rtl/br_resolve_pipe_cmp_core.sv
// Combinational RV32I branch-condition evaluator; funct3 010/011 are flagged
// illegal and resolve not-taken.
module cmp_core
    import br_resolve_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    input  logic [2:0]       cmpop,
    output logic             taken,
    output logic             illegal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (first == second);
    assign lt_s = ($signed(first) < $signed(second));
    assign lt_u = (first < second);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (cmpop)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/br_resolve_pipe.sv
// Pipelined branch resolver: compare at the accept edge, carry the result
// through STAGES registers under a global advance, count consumed branches.
module br_resolve_pipe
    import br_resolve_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = BR_TAG_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    input  logic [2:0]       cmpop,
    input  logic             pred_taken,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    input  logic             clr_stats,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    logic      cmp_taken;
    logic      cmp_illegal;
    logic      adv;
    logic      out_fire;
    br_stage_t head;
    br_stage_t tail;
    br_stage_t chain [STAGES+1];

    cmp_core #(.WIDTH(WIDTH)) u_cmp (
        .first   (first),
        .second  (second),
        .cmpop   (cmpop),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        head.valid   = in_valid && in_ready;
        head.taken   = cmp_taken;
        head.pred    = pred_taken;
        head.illegal = cmp_illegal;
        head.tag     = BR_TAG_W'(in_tag);
    end

    assign chain[0] = head;

    // The whole pipe moves in lockstep; a stall anywhere holds every stage.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        br_stage_t q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
            end else if (flush) begin
                q.valid <= 1'b0;
            end else if (adv) begin
                q <= chain[g];
            end
        end

        assign chain[g+1] = q;
    end

    assign tail           = chain[STAGES];
    assign out_valid      = tail.valid;
    assign out_taken      = tail.taken;
    assign out_illegal    = tail.illegal;
    assign out_mispredict = tail.illegal || (tail.taken != tail.pred);
    assign out_tag        = TAG_W'(tail.tag);

    // Counters saturate; a clear wins over a same-cycle handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (clr_stats) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (out_fire) begin
            if (branch_cnt != {CNT_W{1'b1}}) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (out_mispredict && (mispredict_cnt != {CNT_W{1'b1}})) begin
                mispredict_cnt <= mispredict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_br_resolve_pipe.sv
// Three instances (STAGES 1..3, 4-bit counters) share one stimulus stream and
// are checked every cycle against a slot-array model plus directed literals.
module tb_br_resolve_pipe;

    localparam int CMAX = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] first = '0;
    logic [31:0] second = '0;
    logic [2:0]  cmpop = '0;
    logic        pred_taken = 1'b0;
    logic [4:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        clr_stats = 1'b0;
    logic        out_ready = 1'b1;

    logic        ir [3];
    logic        ov [3];
    logic        ot [3];
    logic        om [3];
    logic        oi [3];
    logic [4:0]  otag [3];
    logic [3:0]  bc [3];
    logic [3:0]  mc [3];

    int checks = 0;
    int errors = 0;

    logic       mv [3][3];
    logic       mt [3][3];
    logic       mp [3][3];
    logic       mi [3][3];
    logic [4:0] mtag [3][3];
    int         mbc [3];
    int         mmc [3];
    logic [4:0] got_q [3][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        br_resolve_pipe #(.WIDTH(32), .STAGES(g + 1), .TAG_W(5), .CNT_W(4)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .in_valid       (in_valid),
            .in_ready       (ir[g]),
            .first          (first),
            .second         (second),
            .cmpop          (cmpop),
            .pred_taken     (pred_taken),
            .in_tag         (in_tag),
            .flush          (flush),
            .clr_stats      (clr_stats),
            .out_valid      (ov[g]),
            .out_ready      (out_ready),
            .out_taken      (ot[g]),
            .out_mispredict (om[g]),
            .out_illegal    (oi[g]),
            .out_tag        (otag[g]),
            .branch_cnt     (bc[g]),
            .mispredict_cnt (mc[g])
        );
    end

    function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic cmp(input int d, input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < 3; s++) begin
                mv[d][s] = 1'b0; mt[d][s] = 1'b0; mp[d][s] = 1'b0;
                mi[d][s] = 1'b0; mtag[d][s] = '0;
            end
            mbc[d] = 0;
            mmc[d] = 0;
        end
    endtask

    // Slot d of instance d is the output slot (depth = d+1).
    task automatic model_step(input int d);
        logic tail_v, tail_mis;
        tail_v   = mv[d][d];
        tail_mis = mi[d][d] || (mt[d][d] != mp[d][d]);
        if (clr_stats) begin
            mbc[d] = 0;
            mmc[d] = 0;
        end else if (tail_v && out_ready) begin
            if (mbc[d] < CMAX) mbc[d]++;
            if (tail_mis && mmc[d] < CMAX) mmc[d]++;
        end
        if (flush) begin
            for (int s = 0; s < 3; s++) mv[d][s] = 1'b0;
        end else if (!tail_v || out_ready) begin
            for (int s = d; s > 0; s--) begin
                mv[d][s] = mv[d][s-1]; mt[d][s] = mt[d][s-1]; mp[d][s] = mp[d][s-1];
                mi[d][s] = mi[d][s-1]; mtag[d][s] = mtag[d][s-1];
            end
            mv[d][0]   = in_valid;
            mt[d][0]   = ref_taken(cmpop, first, second);
            mi[d][0]   = (cmpop == 3'b010) || (cmpop == 3'b011);
            mp[d][0]   = pred_taken;
            mtag[d][0] = in_tag;
        end
    endtask

    task automatic model_check(input int d);
        cmp(d, "in_ready", 32'(ir[d]), 32'(!mv[d][d] || out_ready));
        cmp(d, "out_valid", 32'(ov[d]), 32'(mv[d][d]));
        if (mv[d][d]) begin
            cmp(d, "out_taken", 32'(ot[d]), 32'(mt[d][d]));
            cmp(d, "out_illegal", 32'(oi[d]), 32'(mi[d][d]));
            cmp(d, "out_mispredict", 32'(om[d]), 32'(mi[d][d] || (mt[d][d] != mp[d][d])));
            cmp(d, "out_tag", 32'(otag[d]), 32'(mtag[d][d]));
        end
        cmp(d, "branch_cnt", 32'(bc[d]), 32'(mbc[d]));
        cmp(d, "mispredict_cnt", 32'(mc[d]), 32'(mmc[d]));
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_clear();
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && out_ready) got_q[d].push_back(otag[d]);
                model_step(d);
            end
            #1;
            for (int d = 0; d < 3; d++) model_check(d);
        end
    end

    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic p, input logic [4:0] t);
        @(negedge clk);
        in_valid = v; first = a; second = b; cmpop = op; pred_taken = p; in_tag = t;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, '0, 3'b000, 1'b0, '0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic check_order(input int d, input int n, input int base);
        cmp(d, "order_count", 32'(got_q[d].size()), 32'(n));
        for (int k = 0; k < n && k < got_q[d].size(); k++)
            cmp(d, "order_tag", 32'(got_q[d][k]), 32'(base + k));
    endtask

    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [2:0]  vop [7];
    logic        vp [7];
    logic        vt [7];
    logic        vi [7];
    logic        vm [7];

    initial begin
        model_clear();
        va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3};
        vb = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'h7FFF_FFFF, 32'd4};
        vop = '{3'b100, 3'b110, 3'b111, 3'b010, 3'b011, 3'b101, 3'b001};
        vp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vt = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vi = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vm = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            cmp(d, "rst_out_valid", 32'(ov[d]), 0);
            cmp(d, "rst_in_ready", 32'(ir[d]), 1);
            cmp(d, "rst_out_tag", 32'(otag[d]), 0);
            cmp(d, "rst_branch_cnt", 32'(bc[d]), 0);
        end

        // beq 5,5 predicted not-taken: one-cycle latency on the STAGES=1 instance
        cyc(1'b1, 32'd5, 32'd5, 3'b000, 1'b0, 5'd7);
        after_edge();
        cmp(0, "beq_valid", 32'(ov[0]), 1);
        cmp(0, "beq_taken", 32'(ot[0]), 1);
        cmp(0, "beq_mispredict", 32'(om[0]), 1);
        cmp(0, "beq_tag", 32'(otag[0]), 7);
        cyc(1'b0, '0, '0, 3'b000, 1'b0, '0);
        after_edge();
        cmp(0, "beq_branch_cnt", 32'(bc[0]), 1);
        cmp(0, "beq_mispredict_cnt", 32'(mc[0]), 1);
        idle(4);
        for (int d = 0; d < 3; d++) cmp(d, "drain_branch_cnt", 32'(bc[d]), 1);

        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, va[i], vb[i], vop[i], vp[i], 5'(i + 1));
            after_edge();
            cmp(0, "vec_taken", 32'(ot[0]), 32'(vt[i]));
            cmp(0, "vec_illegal", 32'(oi[0]), 32'(vi[i]));
            cmp(0, "vec_mispredict", 32'(om[0]), 32'(vm[i]));
            cmp(0, "vec_tag", 32'(otag[0]), i + 1);
        end
        idle(4);
        cmp(2, "vec_branch_cnt", 32'(bc[2]), 8);
        cmp(2, "vec_mispredict_cnt", 32'(mc[2]), 4);

        // four back-to-back branches, consumer stalls two cycles
        for (int d = 0; d < 3; d++) got_q[d].delete();
        cyc(1'b1, '0, '0, 3'b000, 1'b1, 5'd1);
        cyc(1'b1, '0, '0, 3'b000, 1'b1, 5'd2);
        cyc(1'b1, '0, '0, 3'b000, 1'b1, 5'd3);
        cyc(1'b1, '0, '0, 3'b000, 1'b1, 5'd4);
        out_ready = 1'b0;
        #1;
        cmp(2, "stall_in_ready_1", 32'(ir[2]), 0);
        @(negedge clk);
        #1;
        cmp(2, "stall_in_ready_2", 32'(ir[2]), 0);
        @(negedge clk);
        out_ready = 1'b1;
        cyc(1'b0, '0, '0, 3'b000, 1'b0, '0);
        idle(6);
        for (int d = 0; d < 3; d++) check_order(d, 4, 1);

        // flush with two in flight and an input offered the same cycle
        for (int d = 0; d < 3; d++) got_q[d].delete();
        cyc(1'b1, 32'd1, 32'd1, 3'b000, 1'b1, 5'd10);
        cyc(1'b1, 32'd1, 32'd1, 3'b000, 1'b1, 5'd11);
        out_ready = 1'b0;
        cyc(1'b1, 32'd1, 32'd1, 3'b000, 1'b1, 5'd12);
        flush = 1'b1;
        after_edge();
        cmp(1, "flush_valid", 32'(ov[1]), 0);
        cyc(1'b1, 32'd1, 32'd1, 3'b000, 1'b1, 5'd13);
        flush = 1'b0;
        out_ready = 1'b1;
        after_edge();
        cmp(1, "post_flush_valid_1", 32'(ov[1]), 0);
        cyc(1'b0, '0, '0, 3'b000, 1'b0, '0);
        after_edge();
        cmp(1, "post_flush_valid_2", 32'(ov[1]), 1);
        cmp(1, "post_flush_tag", 32'(otag[1]), 13);
        idle(5);
        for (int d = 0; d < 3; d++) check_order(d, 1, 13);

        // saturation at 15
        for (int k = 0; k < 20; k++) cyc(1'b1, 32'd1, 32'd2, 3'b000, 1'b0, 5'(k));
        idle(5);
        for (int d = 0; d < 3; d++) begin
            cmp(d, "sat_branch_cnt", 32'(bc[d]), 15);
            cmp(d, "sat_mispredict_cnt", 32'(mc[d]), 4);
        end

        // clear coinciding with a handshake on the STAGES=1 instance
        cyc(1'b1, 32'd2, 32'd2, 3'b000, 1'b0, 5'd9);
        cyc(1'b0, '0, '0, 3'b000, 1'b0, '0);
        clr_stats = 1'b1;
        after_edge();
        clr_stats = 1'b0;
        cmp(0, "clr_branch_cnt", 32'(bc[0]), 0);
        cmp(0, "clr_mispredict_cnt", 32'(mc[0]), 0);
        idle(4);
        cmp(0, "clr_branch_cnt_hold", 32'(bc[0]), 0);

        // asynchronous reset mid-stream
        cyc(1'b1, 32'd7, 32'd8, 3'b001, 1'b1, 5'd20);
        cyc(1'b1, 32'd7, 32'd8, 3'b001, 1'b0, 5'd21);
        cyc(1'b1, 32'd7, 32'd8, 3'b001, 1'b1, 5'd22);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            cmp(d, "arst_out_valid", 32'(ov[d]), 0);
            cmp(d, "arst_branch_cnt", 32'(bc[d]), 0);
            cmp(d, "arst_mispredict_cnt", 32'(mc[d]), 0);
            cmp(d, "arst_out_tag", 32'(otag[d]), 0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) cmp(d, "arst_in_ready", 32'(ir[d]), 1);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
